// File: rtl/rpc_cmd_pkg.sv
// Purpose: shared RPC DRAM command encodings, decoded-entry struct and field helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rpc_cmd_pkg;

  // 4-bit command enum shared with the PHY sequencer; all-zero value is RD.
  typedef enum logic [3:0] {
    CMD_RD      = 4'h0,
    CMD_WR      = 4'h1,
    CMD_ACT     = 4'h2,
    CMD_PRE     = 4'h3,
    CMD_MRS     = 4'h4,
    CMD_REF     = 4'h5,
    CMD_ZQC     = 4'h6,
    CMD_RESET   = 4'h7,
    CMD_INVALID = 4'hF
  } rpc_cmd_e;

  // Raw opcode field values, cmd[18:16].
  localparam logic [2:0] OP_RD  = 3'b000;
  localparam logic [2:0] OP_WR  = 3'b001;
  localparam logic [2:0] OP_MRS = 3'b010;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam logic [2:0] OP_ACT = 3'b101;
  localparam logic [2:0] OP_REF = 3'b110;
  localparam logic [2:0] OP_ZQC = 3'b001;

  // The RESET command is recognised only as this exact word.
  localparam logic [31:0] RESET_WORD = 32'h0000_0001;

  // Value of ref_bank_num for every command other than REF.
  localparam logic [3:0] REF_BANK_NONE = 4'd4;

  typedef struct packed {
    rpc_cmd_e    cmd;
    logic [5:0]  burst_length;
    logic [1:0]  zqc_mode;
    logic [3:0]  ref_bank_num;
  } rpc_cmd_dec_t;

  // Number of banks selected by the 4-bit REF bank mask (0..4).
  function automatic logic [3:0] popcount4(input logic [3:0] v);
    return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]} + {3'b000, v[3]};
  endfunction

endpackage

// File: rtl/rpc_cmd_decoder.sv
// Purpose: combinational decode of one 32-bit raw RPC command word into rpc_cmd_dec_t.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller owns the handshake.
module rpc_cmd_decoder
  import rpc_cmd_pkg::*;
(
  input  logic [31:0]  cmd,
  output rpc_cmd_dec_t dec
);

  logic [2:0] op;
  assign op = cmd[18:16];

  // Classify the word, then fill only the fields that belong to its command.
  always_comb begin
    dec              = '0;
    dec.cmd          = CMD_INVALID;
    dec.ref_bank_num = REF_BANK_NONE;

    if (cmd == RESET_WORD) begin
      dec.cmd = CMD_RESET;
    end else if (!cmd[0]) begin
      case (op)
        OP_RD:   dec.cmd = CMD_RD;
        OP_WR:   dec.cmd = CMD_WR;
        OP_MRS:  dec.cmd = CMD_MRS;
        OP_PRE:  dec.cmd = CMD_PRE;
        OP_ACT:  dec.cmd = CMD_ACT;
        OP_REF:  dec.cmd = CMD_REF;
        default: dec.cmd = CMD_INVALID;
      endcase
    end else if (op == OP_ZQC) begin
      dec.cmd = CMD_ZQC;
    end

    case (dec.cmd)
      CMD_RD, CMD_WR: dec.burst_length = cmd[26:21];
      CMD_REF:        dec.ref_bank_num = popcount4(cmd[25:22]);
      CMD_ZQC:        dec.zqc_mode     = cmd[31:30];
      default:        dec.burst_length = 6'd0;
    endcase
  end

endmodule

// File: rtl/rpc_cmd_decode_queue.sv
// Purpose: decode raw RPC command words and queue decoded entries toward the PHY sequencer; count invalid words.
// Latency: 1 cycle from accept to dec_valid when the queue is empty (no fall-through).
// Backpressure: cmd_ready follows registered occupancy only (fill < FIFO_DEPTH); no path from dec_ready_i.
module rpc_cmd_decode_queue
  import rpc_cmd_pkg::*;
#(
  parameter int DRAM_CMD_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int ERR_CNT_WIDTH  = 8,
  parameter int DROP_INVALID   = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [DRAM_CMD_WIDTH-1:0]        cmd_i,
  output logic                             dec_valid_o,
  input  logic                             dec_ready_i,
  output rpc_cmd_dec_t                     dec_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fill_o,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt_o,
  input  logic                             err_clr_i
);

  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
  // A one-entry queue still needs a 1-bit pointer; it simply never leaves 0.
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]         PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FILL_W-1:0]        FILL_MAX = FILL_W'(FIFO_DEPTH);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;

  rpc_cmd_dec_t        dec_new;
  rpc_cmd_dec_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]   fill_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  logic accept, is_invalid, push, pop;

  rpc_cmd_decoder u_decoder (
    .cmd (cmd_i),
    .dec (dec_new)
  );

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready_o = (fill_q < FILL_MAX);
  assign dec_valid_o = (fill_q != '0);
  // Gate the head so stale or never-written slots are not visible while empty.
  assign dec_o       = dec_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fill_o      = fill_q;
  assign err_cnt_o   = err_cnt_q;

  assign accept     = cmd_valid_i && cmd_ready_o;
  assign is_invalid = (dec_new.cmd == CMD_INVALID);
  // Dropped invalid words are still accepted and counted, they just never occupy a slot.
  assign push       = accept && !((DROP_INVALID != 0) && is_invalid);
  assign pop        = dec_valid_o && dec_ready_i;

  // Queue pointers and occupancy; push and pop in the same cycle leave fill unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Entry storage: written only on push, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= dec_new;
  end

  // Saturating invalid-word counter; a clear coinciding with an invalid accept counts that word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (err_clr_i) begin
      err_cnt_q <= (accept && is_invalid) ? ERR_CNT_WIDTH'(1) : '0;
    end else if (accept && is_invalid && (err_cnt_q != ERR_MAX)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_rpc_cmd_decode_queue.sv
// Purpose: randomized + directed self-checking bench for rpc_cmd_decode_queue against a queue-based model.
// Latency: model expects accepted words at the head one cycle after acceptance.
// Backpressure: random dec_ready stalls; cmd held stable while offered and not accepted.
module tb_rpc_cmd_decode_queue;
  import rpc_cmd_pkg::*;

  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd;
  logic         dec_valid;
  logic         dec_ready;
  rpc_cmd_dec_t dec;
  logic [2:0]   fill;
  logic [7:0]   err_cnt;
  logic         err_clr;

  rpc_cmd_decode_queue #(
    .DRAM_CMD_WIDTH (32),
    .FIFO_DEPTH     (DEPTH),
    .ERR_CNT_WIDTH  (8),
    .DROP_INVALID   (1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_i       (cmd),
    .dec_valid_o (dec_valid),
    .dec_ready_i (dec_ready),
    .dec_o       (dec),
    .fill_o      (fill),
    .err_cnt_o   (err_cnt),
    .err_clr_i   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  rpc_cmd_dec_t mq[$];
  int           merr     = 0;
  bit           last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference decode written straight from the command table.
  function automatic rpc_cmd_dec_t ref_decode(input logic [31:0] w);
    rpc_cmd_dec_t d;
    rpc_cmd_e     c;
    logic [2:0]   op;
    op = w[18:16];
    if (w == 32'h0000_0001)      c = CMD_RESET;
    else if (w[0] == 1'b1)       c = (op == 3'b001) ? CMD_ZQC : CMD_INVALID;
    else begin
      case (op)
        3'b100:  c = CMD_PRE;
        3'b010:  c = CMD_MRS;
        3'b101:  c = CMD_ACT;
        3'b001:  c = CMD_WR;
        3'b000:  c = CMD_RD;
        3'b110:  c = CMD_REF;
        default: c = CMD_INVALID;
      endcase
    end
    d = '0;
    d.cmd = c;
    d.ref_bank_num = 4'd4;
    if (c == CMD_RD || c == CMD_WR) d.burst_length = w[26:21];
    if (c == CMD_REF)               d.ref_bank_num = 4'($countones(w[25:22]));
    if (c == CMD_ZQC)               d.zqc_mode     = w[31:30];
    return d;
  endfunction

  // One clock: predict from pre-edge inputs, advance the model, compare all outputs.
  task automatic step();
    bit           exp_rdy, acc, pop, inv;
    rpc_cmd_dec_t d;
    rpc_cmd_dec_t head;
    exp_rdy = (mq.size() < DEPTH);
    acc     = rst_n && cmd_valid && exp_rdy;
    pop     = rst_n && (mq.size() != 0) && dec_ready;
    d       = ref_decode(cmd);
    inv     = (d.cmd == CMD_INVALID);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mq.delete();
      merr = 0;
    end else begin
      if (pop) head = mq.pop_front();
      if (acc && !inv) mq.push_back(d);
      if (err_clr)                      merr = (acc && inv) ? 1 : 0;
      else if (acc && inv && merr < 255) merr++;
    end
    last_acc = acc;
    head = (mq.size() != 0) ? mq[0] : '0;
    chk("fill",      32'(fill),      32'(mq.size()));
    chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
    chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
    chk("dec",       32'(dec),       32'(head));
    chk("err_cnt",   32'(err_cnt),   32'(merr));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0:       w = 32'h0000_0001;
      1, 2:    w = w;
      default: w[0] = 1'b0;
    endcase
    return w;
  endfunction

  logic [31:0]  dw [5];
  rpc_cmd_dec_t de [5];

  initial begin
    int acc_cnt;
    int cyc;

    dw[0] = 32'h00A0_0000; de[0] = '{CMD_RD,    6'd5,  2'd0, 4'd4};
    dw[1] = 32'h07E1_0000; de[1] = '{CMD_WR,    6'd63, 2'd0, 4'd4};
    dw[2] = 32'h02C6_0000; de[2] = '{CMD_REF,   6'd0,  2'd0, 4'd3};
    dw[3] = 32'h8001_0001; de[3] = '{CMD_ZQC,   6'd0,  2'd2, 4'd4};
    dw[4] = 32'h0000_0001; de[4] = '{CMD_RESET, 6'd0,  2'd0, 4'd4};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd = '0; dec_ready = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_valid", 32'(dec_valid), 32'd0);
    chk("idle_fill",  32'(fill),      32'd0);
    chk("idle_err",   32'(err_cnt),   32'd0);

    // Directed decodes: visible one cycle after the push, then popped.
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd = dw[i]; dec_ready = 1'b1;
      step();
      chk("dir_valid", 32'(dec_valid), 32'd1);
      chk("dir_dec",   32'(dec),       32'(de[i]));
      cmd_valid = 1'b0;
      step();
    end

    // Fill to full with consumer stalled, then drain and check order.
    dec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cmd_valid = 1'b1; cmd = 32'(i + 1) << 21;
      step();
    end
    chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_fill",  32'(fill),      32'(DEPTH));
    cmd = 32'h0FE0_0000;
    step();
    cmd_valid = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("order", 32'(dec.burst_length), 32'(i + 1));
      step();
    end
    chk("drained", 32'(fill), 32'd0);

    // Random traffic with stalls and occasional error clears.
    acc_cnt = 0;
    cyc     = 0;
    cmd_valid = 1'b0;
    last_acc  = 1'b0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      if (!(cmd_valid && !last_acc)) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd       = rand_word();
      end
      dec_ready = ($urandom_range(0, 9) < 6);
      err_clr   = ($urandom_range(0, 99) == 0);
      step();
      if (last_acc) acc_cnt++;
      cyc++;
    end
    chk("rand_budget", 32'(acc_cnt), 32'd1000);
    cmd_valid = 1'b0; err_clr = 1'b0; dec_ready = 1'b1;
    repeat (DEPTH + 2) step();

    // Reset in the middle of queued traffic discards everything.
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd = 32'h0040_0000;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; cmd_valid = 1'b0;
    step();
    chk("rst_mid_fill",  32'(fill),      32'd0);
    chk("rst_mid_valid", 32'(dec_valid), 32'd0);

    // Invalid words are dropped and the counter saturates.
    cmd_valid = 1'b1; cmd = 32'h0002_0001; dec_ready = 1'b1;
    repeat (300) step();
    chk("err_sat",    32'(err_cnt), 32'd255);
    chk("inv_nofill", 32'(fill),    32'd0);
    err_clr = 1'b1;
    step();
    chk("err_clr_inv", 32'(err_cnt), 32'd1);
    cmd_valid = 1'b0;
    step();
    chk("err_clr", 32'(err_cnt), 32'd0);
    err_clr = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
